stack_transfer_sequencer: RTL and testbench
===========================================

// Module: stack_transfer_sequencer
// PURPOSE
//   Sequences multi-register PUSH {rlist[,LR]} / POP {rlist[,PC]} over the memory address handler.
//   Issues one single-word stack transfer per register by driving the handler control code:
//   1 = push, 2 = pop, 0 = idle.
//   Checks stack bounds for the whole list up front; a transfer that would leave the stack region raises a fault and no memory access occurs.
//   Sits between instruction decode and the memory address handler / register file write port.
// PARAMETERS
//   WORD_SIZE            32    datapath width
//   KERNEL_STACK_TOP     4096  lowest legal kernel SP
//   KERNEL_STACK_BOTTOM  6143  highest legal kernel SP
//   USER_STACK_TOP       6144  lowest legal user SP
//   USER_STACK_BOTTOM    8191  highest legal user SP
//   REG_LIST_WIDTH       8     low-register list width (r0..r7)
// PORTS
//   clock           in   1          rising-edge clock
//   reset           in   1          synchronous, active-low
//   start           in   1          request; sampled only in IDLE
//   is_pop          in   1          0 = PUSH, 1 = POP (latched at start)
//   reg_list        in   REG_LIST_WIDTH  register mask (latched at start)
//   extra_reg       in   1          PUSH: include LR (r14); POP: include PC (r15)
//   is_kernel       in   1          selects stack bounds (latched at start)
//   current_SP      in   WORD_SIZE  live SP from register file
//   mem_ready       in   1          memory completes the current access this cycle
//   handler_control out  3          control code to the address handler
//   reg_index       out  4          register being transferred
//   mem_req         out  1          access in progress
//   mem_write       out  1          store strobe (PUSH)
//   reg_write       out  1          register-file write strobe (POP), 1 cycle per word
//   busy            out  1          high from the cycle after start is accepted until done/fault
//   done            out  1          1-cycle pulse: list completed
//   fault           out  1          1-cycle pulse: bounds violation, zero transfers made
// BEHAVIOUR
//   Reset (reset==0 at clock edge): state=IDLE; all outputs 0; latched list cleared.
//     Applies mid-operation: no further strobes, and no done or fault pulse.
//   States: IDLE -> CHECK -> XFER -> FINISH -> IDLE; CHECK -> FAULT -> IDLE.
//   IDLE: when start==1, latch is_pop, mask = {extra_reg, reg_list}, is_kernel, SP0 = current_SP; go to CHECK.
//   CHECK (1 cycle): n = popcount(mask), range 0..9. Checks use full WORD_SIZE arithmetic, no wrap:
//     PUSH faults if SP0 < TOP + n; POP faults if SP0 + n > BOTTOM + 1.
//     Fault -> FAULT. n==0 -> FINISH. Otherwise -> XFER.
//   XFER: mem_req=1 and handler_control = 1 (push) or 2 (pop).
//     reg_index order:
//       PUSH: highest first, i.e. LR(14) if selected, then r7 down to r0.
//       POP:  lowest first, i.e. r0 up to r7, then PC(15) if selected.
//     mem_write = mem_req & ~is_pop (level). reg_write = mem_req & is_pop & mem_ready.
//     While mem_ready==0: hold all outputs unchanged.
//     When mem_ready==1: clear the current mask bit. If it was the last bit -> FINISH, else stay in XFER with the next index.
//   FINISH: handler_control=0, done=1 for one cycle -> IDLE. FAULT: fault=1 for one cycle -> IDLE.
//   handler_control is 0 in every state other than XFER.
//   current_SP is sampled only in IDLE; the sequencer never writes SP (the handler does).
//   start is ignored in every state other than IDLE; no queuing.
//   Latency with mem_ready tied to 1: start accepted at cycle 0; n transfers in cycles 2..n+1; done at cycle n+2.
//     Empty list: done at cycle 2. Fault: fault at cycle 2.
// TESTING
//   1. PUSH, reg_list=8'b1000_0101, extra_reg=1, SP0=8000, user, mem_ready=1
//        -> indices 14,7,2,0 in cycles 2..5, mem_write=1 each, done at cycle 6.
//   2. POP, reg_list=8'b0000_0011, extra_reg=1, SP0=8189, user
//        -> indices 0,1,15, three reg_write pulses, done at cycle 5, no fault.
//   3. PUSH, 3 registers, kernel, SP0=4098
//        -> fault pulse at cycle 2; mem_req, mem_write and handler_control stay 0.
//   4. POP, 2 registers, mem_ready low for 3 cycles on the first word
//        -> index 0 and control 2 held 4 cycles, exactly one reg_write per word.
//   5. reset=0 during the second of 4 PUSH transfers
//        -> next cycle all outputs 0, IDLE; a new start is accepted normally; no done.
//   6. start pulsed while busy, and empty list with extra_reg=0
//        -> the second start is ignored; the empty list gives done at cycle 2 with zero mem_req.

Source files
------------

// File: rtl/stack_transfer_sequencer.sv
// Sequences multi-register PUSH/POP as one single-word stack transfer per register,
// with an up-front stack bounds check over the whole list.
module stack_transfer_sequencer #(
    parameter int unsigned WORD_SIZE           = 32,
    parameter int unsigned KERNEL_STACK_TOP    = 4096,
    parameter int unsigned KERNEL_STACK_BOTTOM = 6143,
    parameter int unsigned USER_STACK_TOP      = 6144,
    parameter int unsigned USER_STACK_BOTTOM   = 8191,
    parameter int unsigned REG_LIST_WIDTH      = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      is_pop,
    input  logic [REG_LIST_WIDTH-1:0] reg_list,
    input  logic                      extra_reg,
    input  logic                      is_kernel,
    input  logic [WORD_SIZE-1:0]      current_SP,
    input  logic                      mem_ready,
    output logic [2:0]                handler_control,
    output logic [3:0]                reg_index,
    output logic                      mem_req,
    output logic                      mem_write,
    output logic                      reg_write,
    output logic                      busy,
    output logic                      done,
    output logic                      fault
);

    localparam int unsigned MaskW = REG_LIST_WIDTH + 1;
    localparam int unsigned PosW  = $clog2(MaskW);
    localparam int unsigned CntW  = $clog2(MaskW + 1);
    localparam int unsigned ExtW  = WORD_SIZE + 2;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StXfer,
        StFinish,
        StFault
    } state_e;

    state_e               state_q;
    logic                 is_pop_q;
    logic                 is_kernel_q;
    logic [MaskW-1:0]     mask_q;
    logic [WORD_SIZE-1:0] sp0_q;
    logic [2:0]           ctrl_q;
    logic [3:0]           index_q;
    logic                 mem_req_q;
    logic                 mem_write_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 fault_q;

    logic [CntW-1:0]  cnt;
    logic [PosW-1:0]  pos_cur;
    logic [PosW-1:0]  pos_next;
    logic [MaskW-1:0] mask_next;
    logic [ExtW-1:0]  sp_ext;
    logic [ExtW-1:0]  n_ext;
    logic [ExtW-1:0]  top_ext;
    logic [ExtW-1:0]  bot_ext;
    logic             bound_fault;

    // POP walks lowest bit first, PUSH walks highest bit first.
    function automatic logic [PosW-1:0] pick(input logic [MaskW-1:0] m, input logic low_first);
        logic [PosW-1:0] p;
        p = '0;
        if (low_first) begin
            for (int i = MaskW - 1; i >= 0; i--) begin
                if (m[i]) p = PosW'(i);
            end
        end else begin
            for (int i = 0; i < MaskW; i++) begin
                if (m[i]) p = PosW'(i);
            end
        end
        return p;
    endfunction

    // The top mask bit stands for LR on PUSH and PC on POP.
    function automatic logic [3:0] pos_to_reg(input logic [PosW-1:0] p, input logic pop);
        logic [3:0] r;
        if (32'(p) == MaskW - 1) r = pop ? 4'd15 : 4'd14;
        else                     r = 4'(p);
        return r;
    endfunction

    always_comb begin
        cnt = '0;
        for (int i = 0; i < MaskW; i++) begin
            cnt = cnt + CntW'(mask_q[i]);
        end
        pos_cur   = pick(mask_q, is_pop_q);
        mask_next = mask_q & ~(MaskW'(1) << pos_cur);
        pos_next  = pick(mask_next, is_pop_q);

        // Widened so neither SP + n nor TOP + n can wrap.
        sp_ext  = ExtW'(sp0_q);
        n_ext   = ExtW'(cnt);
        top_ext = is_kernel_q ? ExtW'(KERNEL_STACK_TOP) : ExtW'(USER_STACK_TOP);
        bot_ext = is_kernel_q ? ExtW'(KERNEL_STACK_BOTTOM) : ExtW'(USER_STACK_BOTTOM);
        bound_fault = is_pop_q ? (sp_ext + n_ext > bot_ext + ExtW'(1))
                               : (sp_ext < top_ext + n_ext);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            is_pop_q    <= 1'b0;
            is_kernel_q <= 1'b0;
            mask_q      <= '0;
            sp0_q       <= '0;
            ctrl_q      <= 3'd0;
            index_q     <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        is_pop_q    <= is_pop;
                        is_kernel_q <= is_kernel;
                        mask_q      <= {extra_reg, reg_list};
                        sp0_q       <= current_SP;
                        busy_q      <= 1'b1;
                        state_q     <= StCheck;
                    end
                end
                StCheck: begin
                    if (bound_fault) begin
                        fault_q <= 1'b1;
                        state_q <= StFault;
                    end else if (mask_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        mem_req_q   <= 1'b1;
                        mem_write_q <= ~is_pop_q;
                        ctrl_q      <= is_pop_q ? 3'd2 : 3'd1;
                        index_q     <= pos_to_reg(pos_cur, is_pop_q);
                        state_q     <= StXfer;
                    end
                end
                StXfer: begin
                    if (mem_ready) begin
                        mask_q <= mask_next;
                        if (mask_next == '0) begin
                            mem_req_q   <= 1'b0;
                            mem_write_q <= 1'b0;
                            ctrl_q      <= 3'd0;
                            index_q     <= 4'd0;
                            done_q      <= 1'b1;
                            state_q     <= StFinish;
                        end else begin
                            index_q <= pos_to_reg(pos_next, is_pop_q);
                        end
                    end
                end
                StFinish, StFault: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign handler_control = ctrl_q;
    assign reg_index       = index_q;
    assign mem_req         = mem_req_q;
    assign mem_write       = mem_write_q;
    assign reg_write       = mem_req_q & is_pop_q & mem_ready;
    assign busy            = busy_q;
    assign done            = done_q;
    assign fault           = fault_q;

endmodule

// File: tb/tb_stack_transfer_sequencer.sv
// Scoreboard bench: the driver queues the expected transfer/done/fault events from a
// register-list model, and a negedge monitor pops and compares whatever the DUT presents.
module tb_stack_transfer_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_pop = 1'b0;
    logic [7:0]  reg_list = '0;
    logic        extra_reg = 1'b0;
    logic        is_kernel = 1'b0;
    logic [31:0] current_SP = '0;
    logic        mem_ready = 1'b0;
    logic [2:0]  handler_control;
    logic [3:0]  reg_index;
    logic        mem_req, mem_write, reg_write, busy, done, fault;

    stack_transfer_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .is_pop(is_pop), .reg_list(reg_list),
        .extra_reg(extra_reg), .is_kernel(is_kernel), .current_SP(current_SP),
        .mem_ready(mem_ready), .handler_control(handler_control), .reg_index(reg_index),
        .mem_req(mem_req), .mem_write(mem_write), .reg_write(reg_write), .busy(busy),
        .done(done), .fault(fault)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int kind;  // 0 transfer, 1 done, 2 fault
        int idx;
        bit pop;
        int rel;   // expected cycle relative to the start cycle, -1 = any
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   base_cyc = 0;
    bit   mon_en = 0;
    bit   prev_stall = 0;
    logic [8:0] prev_out = '0;

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc - base_cyc);
        end
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind %0d idx %0d want none", kind, reg_index);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == 0 && e.kind == 0) begin
                chk("xfer_index", reg_index, e.idx);
                chk("xfer_ctrl", handler_control, e.pop ? 2 : 1);
                chk("xfer_strobes", {mem_write, reg_write}, e.pop ? 1 : 2);
            end
            if (e.rel >= 0) chk("event_cycle", cyc - base_cyc, e.rel);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (mem_req && mem_ready) check_event(0);
            if (done) check_event(1);
            if (fault) check_event(2);
            chk("strobe_rules",
                (reg_write && !(mem_req && mem_ready)) ||
                (!mem_req && (handler_control != 3'd0 || mem_write)), 0);
            if (prev_stall)
                chk("stall_hold", {reg_index, handler_control, mem_req, mem_write}, prev_out);
            prev_stall = reset && mem_req && !mem_ready;
            prev_out   = {reg_index, handler_control, mem_req, mem_write};
        end
    end

    // mode: 0 = mem_ready tied high, 1 = random stalls, 2 = first word stalled 3 cycles
    task automatic run_op(input bit pop, input logic [7:0] list, input bit extra,
                          input bit kern, input logic [31:0] sp, input int mode, input bit poke);
        int     n;
        longint top, bot, spl;
        bit     flt;
        bit     seen;
        int     rel;
        int     regs[$];
        n   = $countones({extra, list});
        top = kern ? 4096 : 6144;
        bot = kern ? 6143 : 8191;
        spl = longint'(sp);
        flt = pop ? (spl + n > bot + 1) : (spl < top + n);
        if (pop) begin
            for (int i = 0; i < 8; i++) if (list[i]) regs.push_back(i);
            if (extra) regs.push_back(15);
        end else begin
            if (extra) regs.push_back(14);
            for (int i = 7; i >= 0; i--) if (list[i]) regs.push_back(i);
        end
        if (flt) begin
            exp_q.push_back('{2, 0, pop, 2});
        end else begin
            foreach (regs[k]) exp_q.push_back('{0, regs[k], pop, (mode == 0) ? 2 + k : -1});
            exp_q.push_back('{1, 0, pop, (mode == 0) ? n + 2 : -1});
        end

        is_pop = pop; reg_list = list; extra_reg = extra; is_kernel = kern;
        current_SP = sp; start = 1'b1; mem_ready = 1'b1;
        @(posedge clock); #1;
        base_cyc = cyc - 1;
        start = 1'b0;
        is_pop = 1'($urandom); reg_list = 8'($urandom); extra_reg = 1'($urandom);
        is_kernel = 1'($urandom); current_SP = $urandom;
        chk("busy_after_start", busy, 1);

        seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            rel = cyc - base_cyc;
            if (done || fault) begin
                seen = 1;
            end else begin
                case (mode)
                    0:       mem_ready = 1'b1;
                    1:       mem_ready = ($urandom_range(0, 3) != 0);
                    default: mem_ready = !(rel >= 2 && rel <= 4);
                endcase
                if (poke && rel == 3) begin
                    start = 1'b1; is_pop = 1'($urandom); reg_list = 8'($urandom);
                    extra_reg = 1'b1; current_SP = 32'd7000;
                end else begin
                    start = 1'b0;
                end
                @(posedge clock); #1;
            end
        end
        chk("op_completes", seen, 1);
        start = 1'b0;
        mem_ready = 1'b0;
        @(posedge clock); #1;
        chk("idle_after_op", busy, 0);
    endtask

    initial begin
        logic [31:0] sp;
        int          sel;
        bit          kern;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", {handler_control, reg_index, mem_req, mem_write, reg_write, busy,
                            done, fault}, 0);
        reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clock); #1;

        run_op(1'b0, 8'b1000_0101, 1'b1, 1'b0, 32'd8000, 0, 1'b0);
        run_op(1'b1, 8'b0000_0011, 1'b1, 1'b0, 32'd8189, 0, 1'b0);
        run_op(1'b0, 8'b0000_0111, 1'b0, 1'b1, 32'd4098, 0, 1'b0);
        run_op(1'b1, 8'b0000_0011, 1'b0, 1'b0, 32'd7000, 2, 1'b0);

        // Reset during the second of four PUSH transfers: only the first completes.
        exp_q.push_back('{0, 6, 1'b0, 2});
        is_pop = 1'b0; reg_list = 8'b0101_0101; extra_reg = 1'b0; is_kernel = 1'b0;
        current_SP = 32'd8000; start = 1'b1; mem_ready = 1'b1;
        @(posedge clock); #1;
        base_cyc = cyc - 1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0; mem_ready = 1'b0;
        @(posedge clock); #1;
        chk("mid_op_reset_outputs", {handler_control, reg_index, mem_req, mem_write, reg_write,
                                     busy, done, fault}, 0);
        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("mid_op_reset_no_done", exp_q.size(), 0);

        run_op(1'b0, 8'b1111_0000, 1'b0, 1'b0, 32'd8000, 0, 1'b1);
        run_op(1'b0, 8'b0000_0000, 1'b0, 1'b0, 32'd8000, 0, 1'b0);
        run_op(1'b1, 8'b1111_1111, 1'b1, 1'b1, 32'd6135, 0, 1'b0);
        run_op(1'b1, 8'b1111_1111, 1'b1, 1'b1, 32'd6136, 0, 1'b0);
        run_op(1'b0, 8'b1111_1111, 1'b1, 1'b0, 32'd6153, 0, 1'b0);
        run_op(1'b0, 8'b1111_1111, 1'b1, 1'b0, 32'd6152, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            kern = 1'($urandom);
            sel  = $urandom_range(0, 3);
            case (sel)
                0:       sp = (kern ? 32'd4096 : 32'd6144) - 32'd1 + $urandom_range(0, 11);
                1:       sp = (kern ? 32'd6143 : 32'd8191) + 32'd2 - $urandom_range(0, 11);
                2:       sp = kern ? $urandom_range(4096, 6143) : $urandom_range(6144, 8191);
                default: sp = $urandom;
            endcase
            run_op(1'($urandom), ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                   1'($urandom), kern, sp, $urandom_range(0, 1), 1'b0);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
